// File: rtl/ysyx_24070014_mem_arbiter_pkg.sv
// Shared definitions for the IFU/LSU memory arbiter: FSM states, owner tags,
// latency bounds and the memory window the arbiter fronts.
package ysyx_24070014_mem_arbiter_pkg;

    typedef enum logic [1:0] {
        YSYX_24070014_ST_IDLE   = 2'd0,
        YSYX_24070014_ST_WAIT   = 2'd1,
        YSYX_24070014_ST_ACCESS = 2'd2,
        YSYX_24070014_ST_RESP   = 2'd3
    } ysyx_24070014_state_e;

    // Bit position in the request/grant vectors doubles as the owner tag.
    typedef enum logic {
        YSYX_24070014_OWN_IFU = 1'b0,
        YSYX_24070014_OWN_LSU = 1'b1
    } ysyx_24070014_owner_e;

    localparam int          YSYX_24070014_LATENCY_MIN = 0;
    localparam int          YSYX_24070014_LATENCY_MAX = 15;
    localparam int          YSYX_24070014_CNT_W       = 4;
    localparam int          YSYX_24070014_MASK_W      = 4;
    localparam logic [31:0] YSYX_24070014_MEM_BASE    = 32'h8000_0000;
    localparam logic [31:0] YSYX_24070014_MEM_SIZE    = 32'h0800_0000;

endpackage

// File: rtl/ysyx_24070014_mem_arbiter_if.sv
// Bundle of the IFU, LSU and shared-memory channels; slave is the arbiter's
// view, master is the view of the requesters plus the memory behind it.
interface ysyx_24070014_mem_arbiter_if
    import ysyx_24070014_mem_arbiter_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int WORD_LEN   = 32
) ();

    logic                            ifu_req_valid;
    logic                            ifu_req_ready;
    logic [ADDR_WIDTH-1:0]           ifu_addr;
    logic                            ifu_resp_valid;
    logic                            ifu_resp_ready;
    logic [WORD_LEN-1:0]             ifu_rdata;

    logic                            lsu_req_valid;
    logic                            lsu_req_ready;
    logic [ADDR_WIDTH-1:0]           lsu_addr;
    logic [WORD_LEN-1:0]             lsu_wdata;
    logic                            lsu_wen;
    logic [YSYX_24070014_MASK_W-1:0] lsu_mask;
    logic                            lsu_resp_valid;
    logic                            lsu_resp_ready;
    logic [WORD_LEN-1:0]             lsu_rdata;

    logic [ADDR_WIDTH-1:0]           mem_addr;
    logic [WORD_LEN-1:0]             mem_wdata;
    logic                            mem_wen;
    logic [YSYX_24070014_MASK_W-1:0] mem_mask;
    logic [WORD_LEN-1:0]             mem_rdata;

    modport slave (
        input  ifu_req_valid, ifu_addr, ifu_resp_ready,
        input  lsu_req_valid, lsu_addr, lsu_wdata, lsu_wen, lsu_mask, lsu_resp_ready,
        input  mem_rdata,
        output ifu_req_ready, ifu_resp_valid, ifu_rdata,
        output lsu_req_ready, lsu_resp_valid, lsu_rdata,
        output mem_addr, mem_wdata, mem_wen, mem_mask
    );

    modport master (
        output ifu_req_valid, ifu_addr, ifu_resp_ready,
        output lsu_req_valid, lsu_addr, lsu_wdata, lsu_wen, lsu_mask, lsu_resp_ready,
        output mem_rdata,
        input  ifu_req_ready, ifu_resp_valid, ifu_rdata,
        input  lsu_req_ready, lsu_resp_valid, lsu_rdata,
        input  mem_addr, mem_wdata, mem_wen, mem_mask
    );

endinterface

// File: rtl/ysyx_24070014_rr_arb2.sv
// Two-way round-robin arbiter: a tie goes to the side not served last; the
// priority pointer only moves when the caller reports an accepted grant.
module ysyx_24070014_rr_arb2
    import ysyx_24070014_mem_arbiter_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] i_req,
    input  logic       i_take,
    output logic [1:0] o_gnt
);

    ysyx_24070014_owner_e r_prio;

    always_comb begin
        o_gnt = 2'b00;
        unique case (i_req)
            2'b01:   o_gnt = 2'b01;
            2'b10:   o_gnt = 2'b10;
            2'b11:   o_gnt = (r_prio == YSYX_24070014_OWN_IFU) ? 2'b01 : 2'b10;
            default: o_gnt = 2'b00;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_prio <= YSYX_24070014_OWN_IFU;
        end else if (i_take) begin
            r_prio <= o_gnt[0] ? YSYX_24070014_OWN_LSU : YSYX_24070014_OWN_IFU;
        end
    end

endmodule

// File: rtl/ysyx_24070014_mem_arbiter.sv
// Shares one read-write memory port between IFU and LSU, one transaction at a
// time: IDLE -> WAIT (LATENCY cycles) -> ACCESS (1 cycle) -> RESP.
module ysyx_24070014_mem_arbiter
    import ysyx_24070014_mem_arbiter_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int WORD_LEN   = 32,
    parameter int LATENCY    = 1
) (
    input logic                           clk,
    input logic                           reset,
    ysyx_24070014_mem_arbiter_if.slave    bus
);

    localparam logic [YSYX_24070014_CNT_W-1:0] LP_CNT_INIT =
        (LATENCY > 0) ? YSYX_24070014_CNT_W'(LATENCY - 1) : '0;

    ysyx_24070014_state_e            r_state, w_state_nxt;
    logic [YSYX_24070014_CNT_W-1:0]  r_cnt, w_cnt_nxt;
    ysyx_24070014_owner_e            r_owner;
    logic [ADDR_WIDTH-1:0]           r_addr;
    logic [WORD_LEN-1:0]             r_wdata;
    logic                            r_wen;
    logic [YSYX_24070014_MASK_W-1:0] r_mask;
    logic [WORD_LEN-1:0]             r_resp;

    logic [1:0] w_gnt;
    logic       w_idle, w_hs, w_mem_wen, w_ifu_rv, w_lsu_rv, w_resp_hs;

    ysyx_24070014_rr_arb2 u_rr_arb2 (
        .clk    (clk),
        .reset  (reset),
        .i_req  ({bus.lsu_req_valid, bus.ifu_req_valid}),
        .i_take (w_hs),
        .o_gnt  (w_gnt)
    );

    // Readiness is gated by reset so neither side sees ready while it is held.
    assign w_idle            = reset && (r_state == YSYX_24070014_ST_IDLE);
    assign bus.ifu_req_ready = w_idle & w_gnt[0];
    assign bus.lsu_req_ready = w_idle & w_gnt[1];
    assign w_hs              = bus.ifu_req_ready | bus.lsu_req_ready;

    always_comb begin
        // NOTE: every signal written here gets a default first, so no latch is inferred.
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_mem_wen   = 1'b0;
        w_ifu_rv    = 1'b0;
        w_lsu_rv    = 1'b0;
        w_resp_hs   = 1'b0;
        unique case (r_state)
            YSYX_24070014_ST_IDLE: begin
                if (w_hs) begin
                    if (LATENCY > 0) begin
                        w_state_nxt = YSYX_24070014_ST_WAIT;
                        w_cnt_nxt   = LP_CNT_INIT;
                    end else begin
                        w_state_nxt = YSYX_24070014_ST_ACCESS;
                    end
                end
            end
            YSYX_24070014_ST_WAIT: begin
                if (r_cnt == '0) w_state_nxt = YSYX_24070014_ST_ACCESS;
                else             w_cnt_nxt   = r_cnt - 1'b1;
            end
            YSYX_24070014_ST_ACCESS: begin
                w_mem_wen   = r_wen;
                w_state_nxt = YSYX_24070014_ST_RESP;
            end
            YSYX_24070014_ST_RESP: begin
                w_ifu_rv  = (r_owner == YSYX_24070014_OWN_IFU);
                w_lsu_rv  = (r_owner == YSYX_24070014_OWN_LSU);
                w_resp_hs = (w_ifu_rv & bus.ifu_resp_ready) | (w_lsu_rv & bus.lsu_resp_ready);
                if (w_resp_hs) w_state_nxt = YSYX_24070014_ST_IDLE;
            end
            default: w_state_nxt = YSYX_24070014_ST_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= YSYX_24070014_ST_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_owner <= YSYX_24070014_OWN_IFU;
            r_addr  <= '0;
            r_wdata <= '0;
            r_wen   <= 1'b0;
            r_mask  <= '0;
        end else if (w_hs) begin
            if (w_gnt[0]) begin
                r_owner <= YSYX_24070014_OWN_IFU;
                r_addr  <= bus.ifu_addr;
                r_wdata <= '0;
                r_wen   <= 1'b0;
                r_mask  <= '1;
            end else begin
                r_owner <= YSYX_24070014_OWN_LSU;
                r_addr  <= bus.lsu_addr;
                r_wdata <= bus.lsu_wdata;
                r_wen   <= bus.lsu_wen;
                r_mask  <= bus.lsu_mask;
            end
        end
    end

    // Writes answer with zero; reads capture the memory word as ACCESS ends.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_resp <= '0;
        end else if (r_state == YSYX_24070014_ST_ACCESS) begin
            r_resp <= r_wen ? '0 : bus.mem_rdata;
        end
    end

    assign bus.mem_addr       = r_addr;
    assign bus.mem_wdata      = r_wdata;
    assign bus.mem_mask       = r_mask;
    assign bus.mem_wen        = w_mem_wen;
    assign bus.ifu_resp_valid = w_ifu_rv;
    assign bus.lsu_resp_valid = w_lsu_rv;
    assign bus.ifu_rdata      = r_resp;
    assign bus.lsu_rdata      = r_resp;

endmodule

// File: doc/ysyx_24070014_mem_arbiter.md
YSYX_24070014_MEM_ARBITER -- requirements
Module: ysyx_24070014_mem_arbiter

Interface
REQ-001 Parameter ADDR_WIDTH, default 32, address width of all ports.
REQ-002 Parameter WORD_LEN, default 32, data width of all ports.
REQ-003 Parameter LATENCY, default 1, range 0..15; wait cycles inserted before each memory access.
REQ-004 clk  in  1  single clock; all state updates on posedge clk.
REQ-005 reset  in  1  asynchronous, active-low reset (0 = reset asserted).
REQ-006 ifu_req_valid  in  1  instruction-fetch read request.
REQ-007 ifu_req_ready  out  1  IFU request accepted when high together with ifu_req_valid.
REQ-008 ifu_addr  in  ADDR_WIDTH  IFU read address.
REQ-009 ifu_resp_valid  out  1 / ifu_resp_ready  in  1 / ifu_rdata  out  WORD_LEN  IFU response channel.
REQ-010 lsu_req_valid  in  1 / lsu_req_ready  out  1  LSU request handshake.
REQ-011 lsu_addr  in  ADDR_WIDTH / lsu_wdata  in  WORD_LEN / lsu_wen  in  1 / lsu_mask  in  4  LSU request payload.
REQ-012 lsu_resp_valid  out  1 / lsu_resp_ready  in  1 / lsu_rdata  out  WORD_LEN  LSU response channel.
REQ-013 mem_addr  out  ADDR_WIDTH / mem_wdata  out  WORD_LEN / mem_wen  out  1 / mem_mask  out  4  drive the shared read-write memory port.
REQ-014 mem_rdata  in  WORD_LEN  combinational read data from the shared memory port.

Function
REQ-015 FSM states IDLE, WAIT, ACCESS, RESP; exactly one transaction in flight at any time.
REQ-016 IDLE: xxx_req_ready is high only for the requester chosen by arbitration; both low while reset is asserted.
REQ-017 Arbitration, both valid in IDLE: grant the requester not served last (round-robin); after reset, IFU wins the first tie.
REQ-018 Single valid requester in IDLE: that requester is granted in the same cycle.
REQ-019 On handshake: latch addr, wdata, wen, mask and grant owner. IFU requests latch wen=0 and mask=4'b1111.
REQ-020 On handshake: next state is WAIT with counter = LATENCY-1 if LATENCY>0; otherwise next state is ACCESS.
REQ-021 WAIT: decrement the counter each cycle; move to ACCESS in the cycle after the counter reads 0.
REQ-022 ACCESS lasts exactly 1 cycle; mem_wen = latched wen in ACCESS, 0 in every other state.
REQ-023 ACCESS read: capture mem_rdata into the response register at the clock edge that ends ACCESS.
REQ-024 ACCESS write: load the response register with 0; the write completes on that same edge.
REQ-025 mem_addr, mem_wdata and mem_mask always drive the latched values; these are don't-care outside ACCESS, but mem_wen must be 0 there.
REQ-026 RESP: assert resp_valid only to the owner. Hold rdata stable until resp_ready is high, then go to IDLE.
REQ-027 Minimum request-to-response latency is LATENCY+2 cycles (handshake edge, LATENCY waits, ACCESS, RESP visible).
REQ-028 No new request is accepted before the previous response handshake completes (no back-to-back overlap).
REQ-029 A requester holding req_valid while not granted is neither dropped nor reordered; it keeps req_valid high until served.

Reset
REQ-030 While reset=0: state IDLE, mem_wen 0, all resp_valid 0, all req_ready 0, response register 0, counter 0, round-robin pointer = IFU.
REQ-031 Reset asserted mid-transaction aborts it immediately. Any write not yet in ACCESS is never issued, and any pending response is discarded.
REQ-032 First acceptance is possible in the first cycle after reset deasserts.

Structure
REQ-033 State encodings, LATENCY bounds and memory base/size constants shall live in the shared DEFINITION header with the ysyx_24070014_ prefix.
REQ-034 Round-robin selection shall be one sub-module, ysyx_24070014_rr_arb2 (2 requests, last-grant pointer, grant one-hot out).
REQ-035 Downstream port shall connect directly to the existing read-write memory module instance without glue logic.

Verification
REQ-036 LATENCY=1, IFU read 0x80000000 alone, memory word 0xDEADBEEF: ifu_resp_valid rises 3 cycles after handshake, ifu_rdata=0xDEADBEEF, mem_wen never 1.
REQ-037 LSU write 0x80000010, data 0x12345678, mask 4'b0011: mem_wen is high for exactly 1 cycle; a following read returns 0x00005678 (prior content 0).
REQ-038 IFU and LSU valid in the same cycle after reset, repeated 4 times: grants are IFU, LSU, IFU, LSU.
REQ-039 resp_ready held low for 5 cycles in RESP: resp_valid and rdata stay stable, and no other request is accepted.
REQ-040 Reset pulled low during WAIT of an LSU write: no mem_wen pulse occurs, and after release all outputs match REQ-030.
REQ-041 LATENCY=0: IFU read response is visible 2 cycles after handshake; LATENCY=15: it is visible 17 cycles after handshake.
